// File: rtl/stage_seq_pkg.sv
// stage_seq_pkg: shared FSM state type and default parameters for the stage sequencer
package stage_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH, ERR} seq_state_t;
  localparam int DEF_N_STAGES = 6;
  localparam int DEF_TO_W = 16;
  localparam int DEF_TO_LIMIT = 50000;
endpackage

// File: rtl/next_stage_sel.sv
// next_stage_sel: lowest set mask bit above cur (or from bit 0 when from_start), with none flag
module next_stage_sel
  import stage_seq_pkg::*;
#(
  parameter int N = DEF_N_STAGES
) (
  input  logic [N-1:0] mask,
  input  logic [3:0]   cur,
  input  logic         from_start,
  output logic [3:0]   nxt,
  output logic         none
);
  // scan downward so the lowest qualifying bit is the last one written
  always_comb begin
    nxt = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i] && (from_start || i > int'(cur))) begin
        nxt = 4'(i);
        none = 1'b0;
      end
  end
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: walks enabled pipeline stages in order; STAGE_SEQ_WATCHDOG_EN adds a per-stage watchdog
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int TO_W = DEF_TO_W,
  parameter int TO_LIMIT = DEF_TO_LIMIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                cont,
  input  logic                abort,
  input  logic [N_STAGES-1:0] stage_en,
  input  logic [N_STAGES-1:0] done,
  output logic                state_idle,
  output logic [N_STAGES-1:0] state_stage,
  output logic [N_STAGES-1:0] stage_start,
  output logic [3:0]          cur_stage,
  output logic                frame_done,
  output logic                error
);
  seq_state_t st, st_n;
  logic [3:0] cur, cur_n, nxt;
  logic [N_STAGES-1:0] mask_q, mask_n, start_n, stage_oh;
  logic none;

  next_stage_sel #(.N(N_STAGES)) u_sel (
    .mask(st == IDLE ? stage_en : mask_q),
    .cur(cur),
    .from_start(st != RUN),
    .nxt(nxt),
    .none(none)
  );

  assign stage_oh = st == RUN ? N_STAGES'(1) << cur : '0;
  assign state_idle = st == IDLE;
  assign state_stage = stage_oh;
  assign cur_stage = st == RUN ? cur : 4'd0;
  assign frame_done = st == FINISH;

`ifdef STAGE_SEQ_WATCHDOG_EN
  logic [TO_W-1:0] wd;
  assign error = st == ERR;
  // watchdog restarts on every stage entry and counts only while running
  always_ff @(posedge clk)
    if (reset) wd <= '0;
    else wd <= (st != RUN || |start_n) ? '0 : wd + 1'b1;
`else
  assign error = 1'b0;
`endif

  // next state, next stage index and entry pulses; abort overrides everything
  always_comb begin
    st_n = st;
    cur_n = cur;
    mask_n = mask_q;
    start_n = '0;
    case (st)
      IDLE:
        if (run && |stage_en) begin
          st_n = RUN;
          mask_n = stage_en;
          cur_n = nxt;
          start_n = N_STAGES'(1) << nxt;
        end
      RUN:
        if (|(done & stage_oh)) begin
          if (none) st_n = FINISH;
          else begin
            cur_n = nxt;
            start_n = N_STAGES'(1) << nxt;
          end
        end
`ifdef STAGE_SEQ_WATCHDOG_EN
        else if (wd == TO_W'(TO_LIMIT - 1)) st_n = ERR;
`endif
      FINISH:
        if (cont) begin
          st_n = RUN;
          cur_n = nxt;
          start_n = N_STAGES'(1) << nxt;
        end else st_n = IDLE;
      default: st_n = ERR;
    endcase
    if (abort) begin
      st_n = IDLE;
      start_n = '0;
    end
  end

  // state, latched mask and registered entry pulse
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      cur <= '0;
      mask_q <= '0;
      stage_start <= '0;
    end else begin
      st <= st_n;
      cur <= cur_n;
      mask_q <= mask_n;
      stage_start <= start_n;
    end
endmodule
